obi_sbr_mem: RTL and testbench
==============================

# obi_sbr_mem

Memory-backed OBI subordinate (responder) that answers the requests issued by the OBI manager in `main`. It accepts address-phase transactions with a req/gnt handshake, performs word reads and byte-enabled writes on an internal SRAM model, and returns responses in order through a small response FIFO with rvalid/rready back-pressure. It flags misaligned or out-of-range accesses as error responses and counts them.

## Interface
- DEPTH, 256, number of 32-bit words in `mem`
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- RSP_DEPTH, 2, response FIFO entries (>=1)

- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  A-channel request
- gnt_o  out  1  A-channel grant
- addr_i  in  32  byte address
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables (writes only)
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rready_i  in  1  manager accepts response
- rdata_o  out  32  read data (0 for writes and errors)
- err_o  out  1  error response
- err_cnt_o  out  8  saturating count of error responses issued

## Operation
- Storage: array `mem[0:DEPTH-1]` of 32-bit words; not reset; preloadable by hierarchical `$readmemh` on `mem`.
- Decode: off = addr_i - BASE_ADDR; index = off[31:2]. Error if addr_i[1:0] != 0 or off >= DEPTH*4 (unsigned, so addresses below BASE_ADDR wrap and are errors).
- gnt_o = req_i && (count < RSP_DEPTH); purely combinational, independent of rready_i.
- On grant (req_i && gnt_o):
  - error: no memory access; push {err=1, rdata=0}; err_cnt_o increments, holding at 8'hFF.
  - write: for each b with be_i[b]=1, mem[index][8b+7:8b] <= wdata_i[8b+7:8b]; push {err=0, rdata=0}. be_i=0 is a legal no-op write.
  - read: push {err=0, rdata=mem[index]} sampled at the grant edge. be_i is ignored.
- Response FIFO: circular, write/read pointers wrap modulo RSP_DEPTH, count 0..RSP_DEPTH.
  - rvalid_o = (count != 0); rdata_o/err_o = head entry.
  - pop on rvalid_o && rready_i.
  - push and pop in the same cycle: count unchanged, both pointers advance.
  - Responses are delivered strictly in grant order. A read granted after a write to the same word returns the new data.
- Head outputs stay stable while rvalid_o=1 and rready_i=0.
- Reset: FIFO pointers and count cleared, err_cnt_o=0, mem retained. Responses still in flight are dropped.

## Timing
- Reset values: gnt_o=0 (follows req_i once count=0), rvalid_o=0, rdata_o=0, err_o=0, err_cnt_o=0.
- Grant latency: 0 cycles. gnt_o rises in the same cycle as req_i when the FIFO is not full.
- Response latency: a grant at edge N gives rvalid_o=1 after edge N, in the cycle following the grant, provided the FIFO was empty.
- Throughput: with rready_i=1, RSP_DEPTH>=2 sustains one transaction per cycle. RSP_DEPTH=1 sustains one per 2 cycles, because a full FIFO blocks gnt_o even in a cycle that pops.
- err_cnt_o updates at the grant edge of the erroring request, not when its response is popped.
- Asynchronous reset forces rvalid_o=0 and err_cnt_o=0 immediately, without waiting for a clock edge.

## Test plan
- Reset: assert rst_ni=0 mid-cycle -> rvalid_o=0, err_o=0, rdata_o=0, err_cnt_o=0 with no clock edge; with req_i=1 after release, gnt_o=1.
- Write then read: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> second response rdata_o=0xDEADBEEF, err_o=0; each rvalid_o appears one cycle after its grant.
- Byte enables: over 0xDEADBEEF at 0x10, write 0x11223344 with be=4'b0101, then read 0x10 -> 0xDE22BE44.
- Errors: read 0x3 (misaligned) and read 0x400 (DEPTH=256, out of range) -> both err_o=1, rdata_o=0, err_cnt_o=2; then 255 further errors -> err_cnt_o=8'hFF, with no wrap to 0.
- Back-pressure: hold rready_i=0 and issue reads of 0x0, 0x4, 0x8 -> the first two are granted, gnt_o=0 for the third. Raise rready_i -> responses pop in order, the third is granted once count<2, and the head stays stable while stalled.
- Reset mid-operation: with 2 queued responses and mem[4]=0xCAFEF00D, pulse rst_ni -> rvalid_o=0 and count=0; a subsequent read of 0x10 returns 0xCAFEF00D.

Source files
------------

// File: rtl/obi_sbr_mem.sv
// rtl/obi_sbr_mem.sv - memory-backed OBI subordinate with in-order response FIFO
module obi_sbr_mem #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rsp_rdata [0:RSP_DEPTH-1];
    logic        rsp_err   [0:RSP_DEPTH-1];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          bad;
    logic          grant;
    logic          pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Unsigned offset: addresses below BASE_ADDR wrap high and fall out of range.
    assign off   = addr_i - BASE_ADDR;
    assign idx   = off[AW+1:2];
    assign bad   = (addr_i[1:0] != 2'b00) || ({1'b0, off} >= 33'(DEPTH) * 33'd4);
    assign gnt_o = req_i && (count < CW'(RSP_DEPTH));
    assign grant = gnt_o;

    assign rvalid_o = (count != '0);
    assign pop      = rvalid_o && rready_i;
    assign rdata_o  = rvalid_o ? rsp_rdata[rptr] : 32'h0;
    assign err_o    = rvalid_o && rsp_err[rptr];

    // Memory and FIFO payload carry no reset; only pointers and counters do.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            if (!bad && we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
            rsp_rdata[wptr] <= (bad || we_i) ? 32'h0 : mem[idx];
            rsp_err[wptr]   <= bad;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            err_cnt_o <= 8'h00;
        end else begin
            if (grant) begin
                wptr <= next_ptr(wptr);
            end
            if (pop) begin
                rptr <= next_ptr(rptr);
            end
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (grant && bad && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'h01;
            end
        end
    end
endmodule

// File: tb/tb_obi_sbr_mem.sv
// tb/tb_obi_sbr_mem.sv - self-checking bench for obi_sbr_mem
module tb_obi_sbr_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        rready = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  ecnt;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    obi_sbr_mem #(.DEPTH(256), .BASE_ADDR(32'h0), .RSP_DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rready_i(rready),
        .rdata_o(rdata), .err_o(err), .err_cnt_o(ecnt)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rready;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vt[8];

    // Reference model: word array, queue of {err, rdata}, saturating error tally.
    logic [31:0] mmem [0:255];
    logic [32:0] rq[$];
    int          mecnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic rr);
        @(negedge clk);
        req = r; we = w; addr = a; be = b; wdata = d; rready = rr;
        #1;
    endtask

    task automatic mstep(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic rr);
        logic        g;
        logic        is_err;
        logic [32:0] h;
        logic [31:0] word;
        drive(r, w, a, b, d, rr);
        g = r && (rq.size() < 2);
        chk("m_gnt", {31'h0, gnt}, {31'h0, g});
        chk("m_rvalid", {31'h0, rvalid}, {31'h0, rq.size() != 0});
        if (rq.size() != 0) begin
            h = rq[0];
            chk("m_rdata", rdata, h[31:0]);
            chk("m_err", {31'h0, err}, {31'h0, h[32]});
        end
        chk("m_ecnt", {24'h0, ecnt}, mecnt);
        if (rq.size() != 0 && rr) void'(rq.pop_front());
        if (g) begin
            is_err = (a % 4 != 0) || (a >= 32'd1024);
            if (is_err) begin
                rq.push_back({1'b1, 32'h0});
                if (mecnt < 255) mecnt++;
            end else if (w) begin
                word = mmem[a[9:2]];
                for (int k = 0; k < 4; k++) if (b[k]) word[8*k +: 8] = d[8*k +: 8];
                mmem[a[9:2]] = word;
                rq.push_back({1'b0, 32'h0});
            end else begin
                rq.push_back({1'b0, mmem[a[9:2]]});
            end
        end
    endtask

    initial begin
        //         req we addr      be    wdata         rr   gnt rv rdata         err ecnt
        vt[0] = '{1'b1, 1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0};
        vt[1] = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 8'd0};
        vt[2] = '{1'b1, 1'b1, 32'h10,  4'h5, 32'h11223344, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 8'd0};
        vt[3] = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 8'd0};
        vt[4] = '{1'b1, 1'b0, 32'h3,   4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDE22BE44, 1'b0, 8'd0};
        vt[5] = '{1'b1, 1'b0, 32'h400, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        1'b1, 8'd1};
        vt[6] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 8'd2};
        vt[7] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 8'd2};

        #2;
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_ecnt", {24'h0, ecnt}, 32'h0);
        chk("rst_gnt", {31'h0, gnt}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].req, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, vt[i].rready);
            chk($sformatf("vec%0d_gnt", i), {31'h0, gnt}, {31'h0, vt[i].gnt});
            chk($sformatf("vec%0d_rvalid", i), {31'h0, rvalid}, {31'h0, vt[i].rvalid});
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].rdata);
            chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vt[i].err});
            chk($sformatf("vec%0d_ecnt", i), {24'h0, ecnt}, {24'h0, vt[i].ecnt});
        end

        // Error counter saturation: 2 so far plus 255 more.
        for (int i = 0; i < 255; i++) begin
            drive(1'b1, 1'b0, 32'h3, 4'h0, 32'h0, 1'b1);
            if (i == 200) chk("sat_mid_ecnt", {24'h0, ecnt}, 32'd202);
        end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("sat_ecnt", {24'h0, ecnt}, 32'hFF);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);

        // Back-pressure with a two-entry response queue.
        drive(1'b1, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, 1'b1);
        drive(1'b1, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1, 1'b1);
        drive(1'b1, 1'b1, 32'h8, 4'hF, 32'hC2C2C2C2, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("bp_idle", {31'h0, rvalid}, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("bp_gnt0", {31'h0, gnt}, 32'h1);
        drive(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
        chk("bp_gnt1", {31'h0, gnt}, 32'h1);
        chk("bp_head0", rdata, 32'hA0A0A0A0);
        drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
        chk("bp_full_gnt", {31'h0, gnt}, 32'h0);
        chk("bp_stall_a", rdata, 32'hA0A0A0A0);
        drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
        chk("bp_full_gnt2", {31'h0, gnt}, 32'h0);
        chk("bp_stall_b", rdata, 32'hA0A0A0A0);
        drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1);
        chk("bp_pop_gnt", {31'h0, gnt}, 32'h0);
        chk("bp_pop0", rdata, 32'hA0A0A0A0);
        drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1);
        chk("bp_late_gnt", {31'h0, gnt}, 32'h1);
        chk("bp_pop1", rdata, 32'hB1B1B1B1);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("bp_pop2", rdata, 32'hC2C2C2C2);
        chk("bp_pop2_err", {31'h0, err}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("bp_drained", {31'h0, rvalid}, 32'h0);

        // Asynchronous reset with two responses queued.
        drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h3, 4'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("mr_pre_rvalid", {31'h0, rvalid}, 32'h1);
        chk("mr_pre_err", {31'h0, err}, 32'h1);
        chk("mr_pre_ecnt", {24'h0, ecnt}, 32'hFF);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_rvalid", {31'h0, rvalid}, 32'h0);
        chk("mr_err", {31'h0, err}, 32'h0);
        chk("mr_rdata", rdata, 32'h0);
        chk("mr_ecnt", {24'h0, ecnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10; rready = 1'b1;
        #1;
        chk("mr_gnt", {31'h0, gnt}, 32'h1);
        chk("mr_empty", {31'h0, rvalid}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("mr_read_valid", {31'h0, rvalid}, 32'h1);
        chk("mr_read", rdata, 32'hCAFEF00D);

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rq.delete();
        mecnt = 0;
        for (int i = 0; i < 16; i++) mstep(1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b1);
        for (int i = 0; i < 400; i++) begin
            int unsigned k;
            logic [31:0] a;
            k = $urandom_range(0, 9);
            if (k <= 6)      a = 32'($urandom_range(0, 15) * 4);
            else if (k == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (k == 8) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
            else             a = 32'hFFFF_FFFC;
            mstep($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                  4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 9) < 7);
        end
        repeat (3) mstep(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
